riscv_icache_responder: RTL and testbench



---
 rtl/riscv_defs_pkg.sv | 14 +
 rtl/riscv_icache_responder.sv | 118 +++++++++++
 tb/tb_riscv_icache_responder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_defs_pkg.sv
// Shared definitions for the RISC-V fetch path: instruction-TCM responder
// state encodings and common widths.
package riscv_defs_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        ICRESP_IDLE = 2'd0,
        ICRESP_WAIT = 2'd1,
        ICRESP_RESP = 2'd2
    } icresp_state_e;

endpackage

// File: rtl/riscv_icache_responder.sv
// Instruction-fetch responder for cacheless builds: one outstanding fetch,
// one SRAM word read per request, programmable response latency.
module riscv_icache_responder
    import riscv_defs_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    localparam int unsigned AW         = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          icache_rd_i,
    input  logic [31:0]   icache_pc_i,
    input  logic          icache_flush_i,
    input  logic          icache_invalidate_i,
    output logic          icache_accept_o,
    output logic          icache_valid_o,
    output logic          icache_error_o,
    output logic [31:0]   icache_inst_o,
    output logic [31:0]   icache_inst_pc_o,
    output logic          mem_rd_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam bit BYPASS = (WAIT_STATES == 0);

    icresp_state_e     state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              ready_q;
    logic              err_q;
    logic              rd_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   data_q;

    logic [XLEN-1:0]   offset;
    logic              fault;
    logic              handshake;
    logic              unused_c;

    // Address decode on the live request PC.
    assign offset = icache_pc_i - BASE_ADDR;
    assign fault  = (icache_pc_i[1:0] != 2'b00) || (offset >= 32'(4 * MEM_WORDS));

    // Handshake and response strobe; a flush suppresses both.
    always_comb begin
        icache_accept_o = 1'b0;
        icache_valid_o  = 1'b0;
        if (!icache_flush_i) begin
            case (state_q)
                ICRESP_IDLE: icache_accept_o = ready_q;
                ICRESP_RESP: begin
                    icache_accept_o = 1'b1;
                    icache_valid_o  = 1'b1;
                end
                default:     icache_accept_o = 1'b0;
            endcase
        end
    end

    assign handshake  = icache_rd_i && icache_accept_o;
    assign mem_rd_o   = handshake && !fault;
    assign mem_addr_o = offset[AW+1:2];

    // With no wait states the SRAM output is still valid in the response cycle.
    assign icache_error_o   = icache_valid_o && err_q;
    assign icache_inst_o    = (icache_valid_o && !err_q) ? (BYPASS ? mem_rdata_i : data_q) : '0;
    assign icache_inst_pc_o = pc_q;

    assign unused_c = ^{icache_invalidate_i, offset};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ICRESP_IDLE;
            wait_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
        end else begin
            ready_q <= 1'b1;
            rd_q    <= mem_rd_o;
            if (rd_q) begin
                data_q <= mem_rdata_i;
            end
            if (handshake) begin
                pc_q  <= icache_pc_i;
                err_q <= fault;
            end

            if (icache_flush_i) begin
                state_q <= ICRESP_IDLE;
                wait_q  <= '0;
            end else if (handshake) begin
                if (BYPASS) begin
                    state_q <= ICRESP_RESP;
                end else begin
                    state_q <= ICRESP_WAIT;
                    wait_q  <= WAIT_W'(WAIT_STATES);
                end
            end else begin
                case (state_q)
                    ICRESP_WAIT: begin
                        wait_q <= wait_q - WAIT_W'(1);
                        if (wait_q == WAIT_W'(1)) begin
                            state_q <= ICRESP_RESP;
                        end
                    end
                    ICRESP_RESP: state_q <= ICRESP_IDLE;
                    default:     state_q <= ICRESP_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_icache_responder.sv
// Self-checking bench: three responders (0, 2 and 3 wait states) fed by a
// behavioural 1-cycle instruction TCM (riscv_itcm_ram), checked against a transaction model.
module tb_riscv_icache_responder;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int WS [N] = '{0, 2, 3};

    logic clk = 1'b0;
    logic rst_n;
    logic inv;

    logic          rd    [N];
    logic [31:0]   pc    [N];
    logic          flush [N];
    logic          acc   [N];
    logic          val   [N];
    logic          err   [N];
    logic [31:0]   inst  [N];
    logic [31:0]   ipc   [N];
    logic          mrd   [N];
    logic [AW-1:0] maddr [N];
    logic [31:0]   rdata [N];

    logic [31:0] ram [4096];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Transaction model: one pending response with the cycle it is due in.
    bit          m_ready [N];
    bit          m_pend  [N];
    bit          m_perr  [N];
    int          m_due   [N];
    logic [31:0] m_pc    [N];

    bit          e_acc  [N];
    bit          e_val  [N];
    bit          e_err  [N];
    bit          e_mrd  [N];
    bit          e_hs   [N];
    logic [31:0] e_inst [N];
    logic [AW-1:0] e_addr [N];

    always #5 clk = ~clk;

    riscv_icache_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_ni(rst_n), .icache_rd_i(rd[0]), .icache_pc_i(pc[0]),
        .icache_flush_i(flush[0]), .icache_invalidate_i(inv), .icache_accept_o(acc[0]),
        .icache_valid_o(val[0]), .icache_error_o(err[0]), .icache_inst_o(inst[0]),
        .icache_inst_pc_o(ipc[0]), .mem_rd_o(mrd[0]), .mem_addr_o(maddr[0]),
        .mem_rdata_i(rdata[0]));

    riscv_icache_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk_i(clk), .rst_ni(rst_n), .icache_rd_i(rd[1]), .icache_pc_i(pc[1]),
        .icache_flush_i(flush[1]), .icache_invalidate_i(inv), .icache_accept_o(acc[1]),
        .icache_valid_o(val[1]), .icache_error_o(err[1]), .icache_inst_o(inst[1]),
        .icache_inst_pc_o(ipc[1]), .mem_rd_o(mrd[1]), .mem_addr_o(maddr[1]),
        .mem_rdata_i(rdata[1]));

    riscv_icache_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_ni(rst_n), .icache_rd_i(rd[2]), .icache_pc_i(pc[2]),
        .icache_flush_i(flush[2]), .icache_invalidate_i(inv), .icache_accept_o(acc[2]),
        .icache_valid_o(val[2]), .icache_error_o(err[2]), .icache_inst_o(inst[2]),
        .icache_inst_pc_o(ipc[2]), .mem_rd_o(mrd[2]), .mem_addr_o(maddr[2]),
        .mem_rdata_i(rdata[2]));

    // riscv_itcm_ram: data one cycle after a read, garbage on every other cycle.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            rdata[k] <= mrd[k] ? ram[maddr[k]] : $urandom;
        end
    end

    function automatic bit is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h0000_4000);
    endfunction

    task automatic set_idle();
        for (int k = 0; k < N; k++) begin
            rd[k] = 1'b0; pc[k] = 32'h0; flush[k] = 1'b0;
        end
        inv = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_ready[k] = 1'b0; m_pend[k] = 1'b0; m_perr[k] = 1'b0; m_pc[k] = 32'h0;
        end
    endtask

    task automatic eval();
        bit due_now;
        #1;
        for (int k = 0; k < N; k++) begin
            due_now   = m_pend[k] && (m_due[k] == cyc);
            e_val[k]  = due_now && !flush[k];
            e_err[k]  = e_val[k] && m_perr[k];
            e_inst[k] = (e_val[k] && !m_perr[k]) ? ram[m_pc[k][13:2]] : 32'h0;
            e_acc[k]  = m_ready[k] && !flush[k] && (!m_pend[k] || due_now);
            e_hs[k]   = rd[k] && e_acc[k];
            e_mrd[k]  = e_hs[k] && !is_fault(pc[k]);
            e_addr[k] = pc[k][13:2];
        end
    endtask

    task automatic tick();
        eval();
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (flush[k] || (m_pend[k] && m_due[k] == cyc)) m_pend[k] = 1'b0;
            if (e_hs[k]) begin
                m_pend[k] = 1'b1;
                m_due[k]  = cyc + 1 + WS[k];
                m_perr[k] = is_fault(pc[k]);
                m_pc[k]   = pc[k];
            end
            m_ready[k] = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #3;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if ({acc[k], val[k], err[k], mrd[k]} !== 4'b0 || inst[k] !== 32'h0 ||
                ipc[k] !== 32'h0 || maddr[k] !== 12'h0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: acc/val/err/mrd=%b%b%b%b inst=%h ipc=%h, want all 0",
                         k, acc[k], val[k], err[k], mrd[k], inst[k], ipc[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) rd[k] = 1'b1;
        eval();
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (acc[k] !== 1'b0 || mrd[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_first[%0d]: acc=%b mrd=%b, want 0 0", k, acc[k], mrd[k]);
            end
        end
        set_idle();
        tick();
        eval();
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (acc[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_second[%0d]: acc=%b, want 1", k, acc[k]);
            end
        end
    endtask

    task automatic test_single();
        rd[0] = 1'b1; pc[0] = 32'h0;
        eval();
        n_tests++;
        if (mrd[0] !== 1'b1 || maddr[0] !== 12'h0 || acc[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_req: mrd=%b addr=%h acc=%b, want 1 000 1", mrd[0], maddr[0], acc[0]);
        end
        tick();
        rd[0] = 1'b0;
        eval();
        n_tests++;
        if (val[0] !== 1'b1 || inst[0] !== 32'h13 || ipc[0] !== 32'h0 || err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp: val=%b inst=%h ipc=%h err=%b, want 1 00000013 0 0",
                     val[0], inst[0], ipc[0], err[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            rd[0] = (i < 3); pc[0] = 32'(4 * i);
            eval();
            n_tests++;
            if (acc[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_accept[%0d]: acc=%b, want 1", i, acc[0]);
            end
            if (i > 0) begin
                n_tests++;
                if (val[0] !== 1'b1 || inst[0] !== ram[i-1] || ipc[0] !== 32'(4 * (i - 1))) begin
                    n_fail++;
                    $display("FAIL b2b_resp[%0d]: val=%b inst=%h ipc=%h, want 1 %h %h",
                             i, val[0], inst[0], ipc[0], ram[i-1], 4 * (i - 1));
                end
            end
            tick();
        end
        rd[0] = 1'b0;
    endtask

    task automatic test_wait_states();
        rd[2] = 1'b1; pc[2] = 32'h10;
        eval();
        n_tests++;
        if (acc[2] !== 1'b1 || mrd[2] !== 1'b1 || maddr[2] !== 12'h4) begin
            n_fail++;
            $display("FAIL ws3_req: acc=%b mrd=%b addr=%h, want 1 1 004", acc[2], mrd[2], maddr[2]);
        end
        tick();
        for (int j = 1; j <= 3; j++) begin
            eval();
            n_tests++;
            if (acc[2] !== 1'b0 || val[2] !== 1'b0 || mrd[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL ws3_wait[%0d]: acc=%b val=%b mrd=%b, want 0 0 0", j, acc[2], val[2], mrd[2]);
            end
            tick();
        end
        rd[2] = 1'b0;
        eval();
        n_tests++;
        if (val[2] !== 1'b1 || inst[2] !== ram[4] || ipc[2] !== 32'h10 || err[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL ws3_resp: val=%b inst=%h ipc=%h err=%b, want 1 %h 00000010 0",
                     val[2], inst[2], ipc[2], err[2], ram[4]);
        end
        tick();
    endtask

    task automatic test_errors();
        rd[0] = 1'b1; pc[0] = 32'h0000_4000;
        eval();
        n_tests++;
        if (mrd[0] !== 1'b0 || acc[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL err_range_req: mrd=%b acc=%b, want 0 1", mrd[0], acc[0]);
        end
        tick();
        pc[0] = 32'h2;
        eval();
        n_tests++;
        if (val[0] !== 1'b1 || err[0] !== 1'b1 || inst[0] !== 32'h0 || ipc[0] !== 32'h4000 || mrd[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL err_range_resp: val=%b err=%b inst=%h ipc=%h mrd=%b, want 1 1 0 00004000 0",
                     val[0], err[0], inst[0], ipc[0], mrd[0]);
        end
        tick();
        rd[0] = 1'b0;
        eval();
        n_tests++;
        if (val[0] !== 1'b1 || err[0] !== 1'b1 || inst[0] !== 32'h0 || ipc[0] !== 32'h2) begin
            n_fail++;
            $display("FAIL err_align_resp: val=%b err=%b inst=%h ipc=%h, want 1 1 0 00000002",
                     val[0], err[0], inst[0], ipc[0]);
        end
        tick();
    endtask

    task automatic test_flush();
        rd[1] = 1'b1; pc[1] = 32'h20;
        tick();
        rd[1] = 1'b0; flush[1] = 1'b1;
        eval();
        n_tests++;
        if (val[1] !== 1'b0 || acc[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wait: val=%b acc=%b, want 0 0", val[1], acc[1]);
        end
        tick();
        flush[1] = 1'b0; rd[1] = 1'b1; pc[1] = 32'h24;
        eval();
        n_tests++;
        if (acc[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_next_accept: acc=%b, want 1", acc[1]);
        end
        tick();
        rd[1] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            eval();
            n_tests++;
            if (val[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_dropped[%0d]: val=%b, want 0", j, val[1]);
            end
            tick();
        end
        eval();
        n_tests++;
        if (val[1] !== 1'b1 || inst[1] !== ram[9] || ipc[1] !== 32'h24) begin
            n_fail++;
            $display("FAIL flush_next_resp: val=%b inst=%h ipc=%h, want 1 %h 00000024",
                     val[1], inst[1], ipc[1], ram[9]);
        end
        tick();
        // Flush beats a handshake in the response cycle.
        rd[0] = 1'b1; pc[0] = 32'h8;
        tick();
        pc[0] = 32'hC; flush[0] = 1'b1;
        eval();
        n_tests++;
        if (val[0] !== 1'b0 || acc[0] !== 1'b0 || mrd[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_resp: val=%b acc=%b mrd=%b, want 0 0 0", val[0], acc[0], mrd[0]);
        end
        tick();
        rd[0] = 1'b0; flush[0] = 1'b0;
        eval();
        n_tests++;
        if (val[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_resp_after: val=%b, want 0", val[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rd[1] = 1'b1; pc[1] = 32'h30;
        tick();
        rd[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if ({acc[k], val[k], err[k], mrd[k]} !== 4'b0 || inst[k] !== 32'h0 || ipc[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: acc/val/err/mrd=%b%b%b%b inst=%h ipc=%h, want all 0",
                         k, acc[k], val[k], err[k], mrd[k], inst[k], ipc[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        eval();
        n_tests++;
        if (acc[1] !== 1'b0 || val[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_first: acc=%b val=%b, want 0 0", acc[1], val[1]);
        end
        tick();
        for (int j = 0; j < 4; j++) begin
            eval();
            n_tests++;
            if (acc[1] !== 1'b1 || val[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_after[%0d]: acc=%b val=%b, want 1 0", j, acc[1], val[1]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++) begin
                rd[k]    = ($urandom_range(0, 9) < 7);
                flush[k] = ($urandom_range(0, 15) == 0);
                r = $urandom_range(0, 9);
                if (r < 7)       pc[k] = 32'($urandom_range(0, 4095)) << 2;
                else if (r == 7) pc[k] = (32'($urandom_range(0, 4095)) << 2) | 32'($urandom_range(1, 3));
                else if (r == 8) pc[k] = 32'h4000 + (32'($urandom_range(0, 4095)) << 2);
                else             pc[k] = $urandom;
            end
            inv = 1'($urandom);
            eval();
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if ({acc[k], val[k], mrd[k], err[k]} !== {e_acc[k], e_val[k], e_mrd[k], e_err[k]} ||
                    ipc[k] !== m_pc[k]) begin
                    n_fail++;
                    $display("FAIL rand_ctl[%0d] c=%0d: acc/val/mrd/err=%b%b%b%b ipc=%h, want %b%b%b%b %h",
                             k, c, acc[k], val[k], mrd[k], err[k], ipc[k],
                             e_acc[k], e_val[k], e_mrd[k], e_err[k], m_pc[k]);
                end
                if (e_val[k]) begin
                    n_tests++;
                    if (inst[k] !== e_inst[k]) begin
                        n_fail++;
                        $display("FAIL rand_inst[%0d] c=%0d: inst=%h, want %h", k, c, inst[k], e_inst[k]);
                    end
                end
                if (e_mrd[k]) begin
                    n_tests++;
                    if (maddr[k] !== e_addr[k]) begin
                        n_fail++;
                        $display("FAIL rand_addr[%0d] c=%0d: addr=%h, want %h", k, c, maddr[k], e_addr[k]);
                    end
                end
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = $urandom;
        ram[0] = 32'h0000_0013;
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_states();
        test_errors();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
